// File: rtl/stream_pipe_pkg.sv
// Shared limits and helpers for the stream_pipe register pipeline.
// Holds the legal parameter ranges and the occupancy counter width.
// No logic; imported by stream_pipe and stream_pipe_stage.
package stream_pipe_pkg;

  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 256;
  localparam int DEPTH_MIN  = 1;
  localparam int DEPTH_MAX  = 16;

  // Counter must represent 0..2*depth inclusive (two entries per stage).
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/stream_pipe_stage.sv
// One skid-buffered pipeline stage: output register plus one skid entry.
// Latency: 1 cycle from input transfer to out_valid when the stage is empty.
// Backpressure: in_ready is a flop, so out_ready never reaches in_ready combinationally.
module stream_pipe_stage
  import stream_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_vld;
  logic [W-1:0] r_out_dat;
  logic         r_skd_vld;
  logic [W-1:0] r_skd_dat;
  logic         r_rdy;

  logic w_in_xfer;
  logic w_out_free;
  logic w_out_vld_nxt;
  logic w_skd_vld_nxt;

  // r_rdy is only ever 1 while the skid entry is empty, so an accepted beat
  // always has somewhere to land even if the output register is held.
  assign w_in_xfer  = in_valid & r_rdy;
  assign w_out_free = ~r_out_vld | out_ready;

  // Next-state of the two valid bits: the output register refills from the
  // skid entry first, otherwise from the incoming beat.
  always_comb begin
    w_out_vld_nxt = r_out_vld;
    w_skd_vld_nxt = r_skd_vld;
    if (w_out_free) begin
      w_out_vld_nxt = r_skd_vld | w_in_xfer;
      w_skd_vld_nxt = 1'b0;
    end else if (w_in_xfer) begin
      w_skd_vld_nxt = 1'b1;
    end
  end

  // Valid bits and registered ready; flush empties the stage and reopens it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_skd_vld <= 1'b0;
      r_rdy     <= 1'b0;
    end else if (flush) begin
      r_out_vld <= 1'b0;
      r_skd_vld <= 1'b0;
      r_rdy     <= 1'b1;
    end else begin
      r_out_vld <= w_out_vld_nxt;
      r_skd_vld <= w_skd_vld_nxt;
      r_rdy     <= ~w_skd_vld_nxt;
    end
  end

  // Payload registers carry no reset; their contents only matter when valid.
  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (r_skd_vld) begin
        r_out_dat <= r_skd_dat;
      end else if (w_in_xfer) begin
        r_out_dat <= in_data;
      end
    end else if (w_in_xfer) begin
      r_skd_dat <= in_data;
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;

endmodule

// File: rtl/stream_pipe.sv
// Valid/ready register pipeline of DEPTH skid stages (2*DEPTH beats), optional parity via STREAM_PIPE_PARITY_EN.
// Latency: DEPTH cycles from acceptance to out_valid when empty; one beat per cycle sustained.
// Backpressure: in_ready comes from a flop in stage 0; flush discards everything in one edge.
module stream_pipe
  import stream_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_par_inj,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]    occupancy,
  output logic                       par_err
);

  localparam int OCC_W = occ_w(DEPTH);

`ifdef STREAM_PIPE_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif

  logic         w_vld [DEPTH+1];
  logic         w_rdy [DEPTH+1];
  logic [W-1:0] w_dat [DEPTH+1];

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] r_occ;

`ifdef STREAM_PIPE_PARITY_EN
  // Parity bit rides above the payload; even parity over {parity, data}.
  assign w_dat[0] = {(^in_data) ^ in_par_inj, in_data};
`else
  assign w_dat[0] = in_data;
  logic w_unused_par_inj;
  assign w_unused_par_inj = in_par_inj;
`endif

  assign w_vld[0]     = in_valid;
  assign w_rdy[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    stream_pipe_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (w_vld[g]),
      .in_ready  (w_rdy[g]),
      .in_data   (w_dat[g]),
      .out_valid (w_vld[g+1]),
      .out_ready (w_rdy[g+1]),
      .out_data  (w_dat[g+1])
    );
  end

  assign in_ready   = w_rdy[0];
  assign out_valid  = w_vld[DEPTH];
  assign out_data   = w_dat[DEPTH][DATA_W-1:0];
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Beat counter: moves only when exactly one side transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;

`ifdef STREAM_PIPE_PARITY_EN
  logic r_par_err;

  // Sticky error: any departing beat with odd parity sets it until flush/reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (flush) begin
      r_par_err <= 1'b0;
    end else if (w_out_xfer && (^w_dat[DEPTH])) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule
